sr_request_arbiter: RTL and testbench
=====================================

# sr_request_arbiter

Round-robin controller that shares one set/reset flag between N requesters whose set and clear requests arrive asynchronously. Each request is synchronized and edge-detected, then held as pending. One request at a time is granted and drives registered, glitch-free S/R pulses to the shared SR latch, with `q`/`qbar` mirroring the latch state. The block sits between asynchronous request sources and the SR latch, and guarantees that S and R are never asserted together.

## Interface
Parameters:
- `N`, 4, number of requesters (2..16)
- `SYNC_STAGES`, 2, synchronizer depth (≥2)
- `HOLD`, 2, cycles S or R is held high per operation (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `n_reset`  in  1  asynchronous, active-low reset
- `set_req`  in  N  asynchronous level requests to set the flag; one bit per requester
- `clr_req`  in  N  asynchronous level requests to clear the flag; one bit per requester
- `S`  out  1  registered set drive to the SR latch
- `R`  out  1  registered reset drive to the SR latch
- `q`  out  1  registered flag state
- `qbar`  out  1  registered complement of `q`
- `ack`  out  N  one-cycle completion pulse to the served requester
- `err`  out  1  one-cycle pulse, coincident with `ack`, marking a conflicting set+clear request
- `owner`  out  $clog2(N)  index of the requester most recently granted
- `busy`  out  1  high whenever the FSM is not IDLE

## Operation
- **Reset.** While `n_reset` is low, all of the following hold immediately (asynchronously):
  - S=0, R=0, q=0, qbar=1, ack=0, err=0, owner=0, busy=0.
  - All synchronizer flops and pending bits are cleared.
  - FSM is in IDLE; round-robin pointer `ptr`=0.
- **Synchronization.** Each `set_req[i]` and `clr_req[i]` passes through `SYNC_STAGES` flops.
  - A rising edge on the synchronized level sets `set_pend[i]` or `clr_pend[i]`.
  - A falling edge has no effect.
  - A rise while the same pending bit is already set is absorbed; that requester gets one operation only.
- **FSM states.** IDLE, DRIVE, ACK.
  - **IDLE:** scan requesters `ptr`, `ptr+1`, … mod N. The first with any pending bit is granted as `g`, and `owner`=`g`.
    - Only `set_pend` set: go to DRIVE with S=1.
    - Only `clr_pend` set: go to DRIVE with R=1.
    - Both set (conflict): go straight to ACK with err=1. No drive; q is unchanged.
    - The granted pending bits clear on the grant edge.
  - **DRIVE:** the active S or R stays high for exactly `HOLD` cycles, counted by a down-counter, then the FSM moves to ACK.
  - **ACK:** S=R=0; `ack[g]`=1 for one cycle.
    - q updates on entry to ACK: 1 after a set, 0 after a clear. qbar = ~q always.
    - Then `ptr` = (`g`+1) mod N and the FSM returns to IDLE.
- **Redundant operations.** A set while q=1, or a clear while q=0, still runs the full DRIVE/ACK sequence.
- **New edges during service.** A rise from the granted requester arriving during DRIVE or ACK re-sets its pending bit. It is served in a later round.
- **Invariant.** S and R are never high together, including across reset deassertion.

## Timing
- Let a request level change be first captured at edge k.
  - The pending bit is set at edge k+`SYNC_STAGES`.
  - S (or R) rises at edge k+`SYNC_STAGES`+1 if the FSM was idle.
- Per operation: IDLE 1 cycle, DRIVE `HOLD` cycles, ACK 1 cycle. Back-to-back grants are therefore `HOLD`+2 cycles apart.
- A conflict takes 2 cycles: IDLE, then ACK.
- Defaults (`SYNC_STAGES`=2, `HOLD`=2): S is high over edges k+3..k+5, `ack` and q=1 appear at k+5, and the next S can rise at k+7 at the earliest.
- Reset asserted mid-DRIVE drops S/R in the same cycle (asynchronously) and discards all pending work. After release, the block starts in IDLE with `ptr`=0.

## Structure
- Package `sr_arb_pkg`: state enum typedef `sr_state_t` {IDLE, DRIVE, ACK} and the `ptr`/`owner` width function.
- Sub-module `sync_rise`: `SYNC_STAGES`-deep synchronizer plus a rising-edge pulse, with async active-low reset. It is instantiated 2N times.
- Top level: pending registers, round-robin search, FSM, HOLD counter, output registers.

## Test plan
- After reset: S=R=0, q=0, qbar=1, busy=0. Pulse `set_req[0]` at edge 0 → S high on edges 3–4, `ack[0]` and q=1 at edge 5, R stays 0 throughout.
- `set_req[1]` and `clr_req[2]` rise in the same cycle → requester 1 is served first (S, q=1), then requester 2 (R, q=0). Acks are 4 cycles apart and `owner` reads 1 then 2.
- `set_req[3]` and `clr_req[3]` rise together → single `ack[3]` with err=1, S=R=0 throughout, q unchanged.
- All N requesters pulse set simultaneously, repeated three times → grant order 0,1,2,3, then the next round continues from `ptr`. No requester is starved.
- Assert `n_reset` low during DRIVE → S drops without waiting for `clk`, q=0, no ack. After release, a pending-free IDLE with busy=0.
- Hold `set_req[0]` high for 20 cycles → exactly one operation. The level falling and rising again produces a second operation.

Source files
------------

// File: rtl/sr_arb_pkg.sv
// Shared types and sizing helpers for the set/reset request arbiter.
package sr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    ACK   = 2'd2
  } sr_state_t;

  // Width of the round-robin pointer / owner index (never below one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the HOLD down-counter, which only ever holds HOLD-1 .. 0.
  function automatic int hold_cnt_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer for one asynchronous level, followed by a
// rising-edge detector. The rise output is a single-cycle pulse.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift the raw level through the synchronizer and keep the previous
  // synchronized value for edge detection.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/sr_request_arbiter.sv
// Round-robin arbiter sharing one SR flag between N asynchronous
// set/clear requesters. All latch drives and status outputs are registered.
//
// state | meaning
// IDLE  | scanning pending bits from ptr; grants the first requester found
// DRIVE | S or R held high for HOLD cycles
// ACK   | drives released, ack pulse to owner, ptr advances past owner
module sr_request_arbiter
  import sr_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD        = 2
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [N-1:0]            set_req,
  input  logic [N-1:0]            clr_req,
  output logic                    S,
  output logic                    R,
  output logic                    q,
  output logic                    qbar,
  output logic [N-1:0]            ack,
  output logic                    err,
  output logic [ptr_width(N)-1:0] owner,
  output logic                    busy
);

  localparam int PW = ptr_width(N);
  localparam int CW = hold_cnt_width(HOLD);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  sr_state_t       state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            op_set;

  logic [N-1:0]    set_rise;
  logic [N-1:0]    clr_rise;
  logic [N-1:0]    set_pend;
  logic [N-1:0]    clr_pend;
  logic [N-1:0]    any_pend;
  logic [N-1:0]    take;
  logic            found;
  logic [PW-1:0]   gnt;
  logic            grant_fire;

  for (genvar gi = 0; gi < N; gi++) begin : g_sync
    sync_rise #(.STAGES(SYNC_STAGES)) u_set_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .din     (set_req[gi]),
      .rise    (set_rise[gi])
    );
    sync_rise #(.STAGES(SYNC_STAGES)) u_clr_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .din     (clr_req[gi]),
      .rise    (clr_rise[gi])
    );
  end

  assign any_pend   = set_pend | clr_pend;
  assign grant_fire = (state == IDLE) && found;
  assign take       = grant_fire ? (ONE << gnt) : '0;

  // Round-robin search: first requester with any pending bit, starting at ptr.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && any_pend[idx]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
  end

  // Pending bits: set by a synchronized rise, cleared on the grant edge.
  // A rise landing on the grant edge wins so it is not lost.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      set_pend <= '0;
      clr_pend <= '0;
    end else begin
      set_pend <= (set_pend & ~take) | set_rise;
      clr_pend <= (clr_pend & ~take) | clr_rise;
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      op_set <= 1'b0;
      S      <= 1'b0;
      R      <= 1'b0;
      q      <= 1'b0;
      qbar   <= 1'b1;
      ack    <= '0;
      err    <= 1'b0;
      owner  <= '0;
      busy   <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= gnt;
            busy  <= 1'b1;
            if (set_pend[gnt] && clr_pend[gnt]) begin
              // Conflicting request: acknowledge with err, latch untouched.
              ack   <= ONE << gnt;
              err   <= 1'b1;
              state <= ACK;
            end else begin
              op_set <= set_pend[gnt];
              S      <= set_pend[gnt];
              R      <= ~set_pend[gnt];
              cnt    <= CW'(HOLD - 1);
              state  <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            S     <= 1'b0;
            R     <= 1'b0;
            ack   <= ONE << owner;
            q     <= op_set;
            qbar  <= ~op_set;
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          ptr   <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          S     <= 1'b0;
          R     <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_request_arbiter.sv
// Directed bench for sr_request_arbiter with default parameters.
module tb_sr_request_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [N-1:0] set_req = '0;
  logic [N-1:0] clr_req = '0;
  logic         S, R, q, qbar, err, busy;
  logic [N-1:0] ack;
  logic [1:0]   owner;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] set_req;
    logic [3:0] clr_req;
    logic       S;
    logic       R;
    logic [3:0] ack;
    logic       q;
    logic       err;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t tbl[$];

  sr_request_arbiter #(.N(N), .SYNC_STAGES(2), .HOLD(2)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .set_req (set_req),
    .clr_req (clr_req),
    .S       (S),
    .R       (R),
    .q       (q),
    .qbar    (qbar),
    .ack     (ack),
    .err     (err),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (S === 1'b1 && R === 1'b1) begin
      failures++;
      $display("FAIL sr_overlap at %0t: S=%b R=%b required not both high", $time, S, R);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] s_in, input logic [3:0] c_in, input logic s_o,
                     input logic r_o, input logic [3:0] a_o, input logic q_o,
                     input logic e_o, input logic b_o, input logic [1:0] o_o);
    vec_t v;
    v.set_req = s_in; v.clr_req = c_in; v.S = s_o; v.R = r_o; v.ack = a_o;
    v.q = q_o; v.err = e_o; v.busy = b_o; v.owner = o_o;
    tbl.push_back(v);
  endtask

  task automatic pulse(input logic [3:0] s_in, input logic [3:0] c_in);
    set_req = s_in;
    clr_req = c_in;
    step();
    step();
    set_req = '0;
    clr_req = '0;
  endtask

  // Steps until an ack appears; returns its index and the cycles waited.
  task automatic wait_ack(input string name, output int idx, output int waited);
    idx = -1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (ack == '0 && waited < 40);
    if (ack == '0) begin
      checks++;
      failures++;
      $display("FAIL %s: ack timeout after %0d cycles, required an ack", name, waited);
    end else begin
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
    end
  endtask

  initial begin
    int idx, waited, acks, bad;
    logic [11:0] act_row, exp_row;
    logic [3:0] exp_order [4];

    // Reset state
    step();
    step();
    check("reset_state", {S, R, ack, q, qbar, err, busy, owner}, {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    n_reset = 1'b1;

    // Single set from requester 0
    add(4'h1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd0);
    add(4'h1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd0);
    add(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd0);
    add(4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 2'd0);
    add(4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 2'd0);
    add(4'h0, 4'h0, 0, 0, 4'h1, 1, 0, 1, 2'd0);
    add(4'h0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 2'd0);
    // Set from 1 and clear from 2 in the same cycle
    add(4'h2, 4'h4, 0, 0, 4'h0, 1, 0, 0, 2'd0);
    add(4'h2, 4'h4, 0, 0, 4'h0, 1, 0, 0, 2'd0);
    add(4'h0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 2'd0);
    add(4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 1, 2'd1);
    add(4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 1, 2'd1);
    add(4'h0, 4'h0, 0, 0, 4'h2, 1, 0, 1, 2'd1);
    add(4'h0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 2'd1);
    add(4'h0, 4'h0, 0, 1, 4'h0, 1, 0, 1, 2'd2);
    add(4'h0, 4'h0, 0, 1, 4'h0, 1, 0, 1, 2'd2);
    add(4'h0, 4'h0, 0, 0, 4'h4, 0, 0, 1, 2'd2);
    add(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd2);
    // Conflicting set+clear from requester 3
    add(4'h8, 4'h8, 0, 0, 4'h0, 0, 0, 0, 2'd2);
    add(4'h8, 4'h8, 0, 0, 4'h0, 0, 0, 0, 2'd2);
    add(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd2);
    add(4'h0, 4'h0, 0, 0, 4'h8, 0, 1, 1, 2'd3);
    add(4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 2'd3);

    foreach (tbl[i]) begin
      set_req = tbl[i].set_req;
      clr_req = tbl[i].clr_req;
      step();
      act_row = {S, R, ack, q, qbar, err, busy, owner};
      exp_row = {tbl[i].S, tbl[i].R, tbl[i].ack, tbl[i].q, ~tbl[i].q, tbl[i].err, tbl[i].busy, tbl[i].owner};
      checks++;
      if (act_row !== exp_row) begin
        failures++;
        $display("FAIL row_%0d {S,R,ack,q,qbar,err,busy,owner}: got %b required %b", i, act_row, exp_row);
      end
    end
    set_req = '0;
    clr_req = '0;

    // Round robin: all requesters at once from ptr=0
    pulse(4'hF, 4'h0);
    for (int i = 0; i < N; i++) begin
      wait_ack("rr_round1", idx, waited);
      check("rr_round1_order", idx, i);
      check("rr_round1_spacing", waited, 4);
    end

    // Move ptr to 2 with a lone request from 1, then two full rounds
    pulse(4'h2, 4'h0);
    wait_ack("rr_single", idx, waited);
    check("rr_single_order", idx, 1);
    exp_order[0] = 4'd2; exp_order[1] = 4'd3; exp_order[2] = 4'd0; exp_order[3] = 4'd1;
    for (int r = 0; r < 2; r++) begin
      pulse(4'hF, 4'h0);
      for (int i = 0; i < N; i++) begin
        wait_ack("rr_rotated", idx, waited);
        check("rr_rotated_order", idx, {28'd0, exp_order[i]});
        check("rr_rotated_spacing", waited, 4);
      end
    end

    // Reset asserted mid-DRIVE (ptr=2, so requester 2 is granted first)
    pulse(4'h5, 4'h0);
    step();
    step();
    check("drive_started", {S, R, owner}, {1'b1, 1'b0, 2'd2});
    #2;
    n_reset = 1'b0;
    #1;
    check("async_reset_mid_drive", {S, R, ack, q, qbar, err, busy, owner}, {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    step();
    step();
    n_reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy !== 1'b0 || S !== 1'b0 || R !== 1'b0 || ack !== '0) bad++;
    end
    check("post_reset_idle_cycles_bad", bad, 0);

    // ptr restarts at 0 after reset: requests 1 and 3 served 1 first
    pulse(4'hA, 4'h0);
    wait_ack("post_reset_rr", idx, waited);
    check("post_reset_first", idx, 1);
    wait_ack("post_reset_rr", idx, waited);
    check("post_reset_second", idx, 3);

    // Long level: one operation only, re-rise gives another
    acks = 0;
    set_req = 4'h1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) set_req = 4'h0;
      step();
      if (ack[0] === 1'b1) acks++;
    end
    check("long_level_ops", acks, 1);
    acks = 0;
    set_req = 4'h1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack[0] === 1'b1) acks++;
    end
    set_req = 4'h0;
    check("rerise_ops", acks, 1);
    check("rerise_q", {q, qbar}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
